jzjpcc_fetch_stage: RTL

- Fetch stage of the pipelined RV32I core. Owns the fetch PC, drives the synchronous instruction memory and produces the fetch/decode pipeline outputs.
- Obeys stall_fetch, stall_decode and flush_decode from the hazard unit.
- Takes control-transfer redirects (pcCTWriteEnable and target) from decode.
- Holds the instruction steady across stalls even though the instruction memory read port has one cycle of latency.

---
 rtl/jzjpcc_fetch_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/jzjpcc_fetch_stage.sv
// Fetch stage for the pipelined RV32I core: owns the fetch PC, drives the synchronous
// instruction memory and holds the fetch/decode pipeline register.
module jzjpcc_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        flush_decode,
    input  logic        pcCTWriteEnable,
    input  logic [31:0] pcCTTarget,
    output logic [29:0] instructionAddress,
    input  logic [31:0] instructionIn,
    output logic [31:0] instruction_decode,
    output logic [31:0] pc_decode,
    output logic [31:0] pcPlus4_decode,
    output logic        valid_decode
);

    logic [31:0] pc_fetch_q, pc_fetch_d;
    logic [31:0] pc_decode_q, pc_decode_d;
    logic        valid_q, valid_d;
    logic        hold_active_q, hold_active_d;
    logic [31:0] hold_instruction_q, hold_instruction_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_fetch_q         <= RESET_VECTOR;
            pc_decode_q        <= '0;
            valid_q            <= 1'b0;
            hold_active_q      <= 1'b0;
            hold_instruction_q <= NOP_INSTRUCTION;
        end else begin
            pc_fetch_q         <= pc_fetch_d;
            pc_decode_q        <= pc_decode_d;
            valid_q            <= valid_d;
            hold_active_q      <= hold_active_d;
            hold_instruction_q <= hold_instruction_d;
        end
    end

    always_comb begin
        pc_fetch_d = pc_fetch_q + 32'd4;
        if (stall_fetch) begin
            pc_fetch_d = pc_fetch_q;
        end else if (pcCTWriteEnable) begin
            pc_fetch_d = pcCTTarget & ~32'h3;
        end
    end

    always_comb begin
        pc_decode_d        = pc_decode_q;
        valid_d            = valid_q;
        hold_active_d      = hold_active_q;
        hold_instruction_d = hold_instruction_q;
        if (flush_decode) begin
            pc_decode_d   = pc_fetch_q;
            valid_d       = 1'b0;
            hold_active_d = 1'b0;
        end else if (stall_decode) begin
            // Memory moves on past the stalled word, so keep a private copy of it.
            hold_instruction_d = instruction_decode;
            hold_active_d      = 1'b1;
        end else begin
            pc_decode_d   = pc_fetch_q;
            valid_d       = 1'b1;
            hold_active_d = 1'b0;
        end
    end

    always_comb begin
        if (!valid_q) begin
            instruction_decode = NOP_INSTRUCTION;
        end else if (hold_active_q) begin
            instruction_decode = hold_instruction_q;
        end else begin
            instruction_decode = instructionIn;
        end
    end

    assign instructionAddress = pc_fetch_q[31:2];
    assign pc_decode          = pc_decode_q;
    assign pcPlus4_decode     = pc_decode_q + 32'd4;
    assign valid_decode       = valid_q;

endmodule
